// File: rtl/pp_reduce_sched.sv
// Row-batching controller for a shared 24-bit 7:2 compressor: five rows per pass plus the
// sum/carry accumulator, then a final carry-propagate add behind a valid/ready handshake.
module pp_reduce_sched #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [CNT_W-1:0] out_rows,
  output logic [CNT_W-1:0] out_passes
);

  typedef enum logic [1:0] {StCollect, StCompress, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] slot_q [5];
  logic [WIDTH-1:0] slot_d [5];
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_s_q, acc_s_d, acc_c_q, acc_c_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] rows_q, rows_d, passes_q, passes_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] orows_q, orows_d, opasses_q, opasses_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WIDTH-1:0] xor3(input logic [WIDTH-1:0] a, b, c);
    return a ^ b ^ c;
  endfunction

  // Carry output is already shifted to its weight; the shifted-out MSB is lost mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] a, b, c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  // 7:2 compressor as a tree of 3:2 carry-save stages.
  logic [WIDTH-1:0] p5, p6, s1, c1, s2, c2, s3, c3, s4, c4, cmp_sum, cmp_carry_w;
  logic [WIDTH-1:0] cmp_carry;
  always_comb begin
    p5          = acc_s_q;
    p6          = acc_c_q << 1;
    s1          = xor3(slot_q[0], slot_q[1], slot_q[2]);
    c1          = maj3(slot_q[0], slot_q[1], slot_q[2]);
    s2          = xor3(slot_q[3], slot_q[4], p5);
    c2          = maj3(slot_q[3], slot_q[4], p5);
    s3          = xor3(s1, c1, s2);
    c3          = maj3(s1, c1, s2);
    s4          = xor3(c2, p6, s3);
    c4          = maj3(c2, p6, s3);
    cmp_sum     = xor3(c3, c4, s4);
    cmp_carry_w = maj3(c3, c4, s4);
    cmp_carry   = cmp_carry_w >> 1;
  end

  // Gated by rst_n so no row is consumed while reset is held.
  assign in_ready   = rst_n && (state_q == StCollect);
  assign out_valid  = (state_q == StDone);
  assign out_result = res_q;
  assign out_rows   = orows_q;
  assign out_passes = opasses_q;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    acc_s_d   = acc_s_q;
    acc_c_d   = acc_c_q;
    last_d    = last_q;
    rows_d    = rows_q;
    passes_d  = passes_q;
    res_d     = res_q;
    orows_d   = orows_q;
    opasses_d = opasses_q;
    unique case (state_q)
      StCollect: begin
        if (in_valid && in_ready) begin
          slot_d[cnt_q] = in_row;
          cnt_d         = cnt_q + 3'd1;
          rows_d        = sat_inc(rows_q);
          if (in_last) last_d = 1'b1;
          if (in_last || cnt_q == 3'd4) state_d = StCompress;
        end
      end
      StCompress: begin
        acc_s_d  = cmp_sum;
        acc_c_d  = cmp_carry;
        for (int i = 0; i < 5; i++) slot_d[i] = '0;
        cnt_d    = '0;
        passes_d = sat_inc(passes_q);
        state_d  = last_q ? StAdd : StCollect;
      end
      StAdd: begin
        res_d     = acc_s_q + (acc_c_q << 1);
        orows_d   = rows_q;
        opasses_d = passes_q;
        acc_s_d   = '0;
        acc_c_d   = '0;
        rows_d    = '0;
        passes_d  = '0;
        last_d    = 1'b0;
        state_d   = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StCollect;
      for (int i = 0; i < 5; i++) slot_q[i] <= '0;
      cnt_q     <= '0;
      acc_s_q   <= '0;
      acc_c_q   <= '0;
      last_q    <= 1'b0;
      rows_q    <= '0;
      passes_q  <= '0;
      res_q     <= '0;
      orows_q   <= '0;
      opasses_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      acc_s_q   <= acc_s_d;
      acc_c_q   <= acc_c_d;
      last_q    <= last_d;
      rows_q    <= rows_d;
      passes_q  <= passes_d;
      res_q     <= res_d;
      orows_q   <= orows_d;
      opasses_q <= opasses_d;
    end
  end

endmodule

// File: tb/tb_pp_reduce_sched.sv
// Directed bench for pp_reduce_sched: hand-computed sums, counts, latency and handshake checks.
module tb_pp_reduce_sched;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [23:0] in_row, out_result;
  logic [7:0]  out_rows, out_passes;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          w;

  always #5 clk = ~clk;

  pp_reduce_sched #(.WIDTH(24), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rows   (out_rows),
    .out_passes (out_passes)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [23:0] row, input logic last, output int waits);
    in_valid = 1'b1;
    in_row   = row;
    in_last  = last;
    waits    = 0;
    while (!in_ready && waits < 20) begin
      step();
      waits++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    else step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic check_out(input string tag, input logic [23:0] res, input logic [7:0] rows,
                           input logic [7:0] passes);
    chk({tag, "_result"}, 64'(out_result), 64'(res));
    chk({tag, "_rows"}, 64'(out_rows), 64'(rows));
    chk({tag, "_passes"}, 64'(out_passes), 64'(passes));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_row = '0; in_last = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    check_out("rst", 24'h0, 8'd0, 8'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", 64'(in_ready), 64'd1);

    // Single row: COMPRESS at t+1, ADD at t+2, valid from t+3.
    send_row(24'h000001, 1'b1, w);
    chk("single_wait", 64'(w), 64'd0);
    chk("single_t1_ready", 64'(in_ready), 64'd0);
    chk("single_t1_valid", 64'(out_valid), 64'd0);
    step();
    chk("single_t2_valid", 64'(out_valid), 64'd0);
    step();
    chk("single_t3_valid", 64'(out_valid), 64'd1);
    check_out("single", 24'h000001, 8'd1, 8'd1);
    handshake("single");

    // Wrap-around: 7 x 0xFFFFFF, one stall cycle after the 5th row.
    for (int i = 1; i <= 7; i++) begin
      send_row(24'hFFFFFF, (i == 7), w);
      if (i == 6) chk("wrap_row6_wait", 64'(w), 64'd1);
      else if (i > 1) chk($sformatf("wrap_row%0d_wait", i), 64'(w), 64'd0);
    end
    wait_out();
    check_out("wrap", 24'hFFFFF9, 8'd7, 8'd2);
    handshake("wrap");

    // Exact batch of five.
    for (int i = 1; i <= 5; i++) send_row(24'(i) << 20, (i == 5), w);
    wait_out();
    check_out("batch", 24'hF00000, 8'd5, 8'd1);
    handshake("batch");

    // Streaming 1..12 with two-cycle upstream gaps after rows 3 and 8.
    for (int i = 1; i <= 12; i++) begin
      send_row(24'(i), (i == 12), w);
      if (i == 3 || i == 8) begin
        step();
        step();
      end
    end
    wait_out();
    check_out("stream", 24'h00004E, 8'd12, 8'd3);

    // Backpressure: everything held while out_ready is low.
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("hold_%0d", i), {out_valid, in_ready, out_result, out_rows, out_passes},
          {1'b1, 1'b0, 24'h00004E, 8'd12, 8'd3});
    end
    handshake("hold");
    send_row(24'h000007, 1'b1, w);
    chk("follow_wait", 64'(w), 64'd0);
    wait_out();
    check_out("follow", 24'h000007, 8'd1, 8'd1);
    handshake("follow");

    // Reset in the middle of collection discards the partial operation.
    for (int i = 0; i < 3; i++) send_row(24'h000100, 1'b0, w);
    rst_n = 1'b0;
    step();
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    check_out("midrst", 24'h0, 8'd0, 8'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 64'(in_ready), 64'd1);
    send_row(24'h000005, 1'b1, w);
    wait_out();
    check_out("after_rst", 24'h000005, 8'd1, 8'd1);
    handshake("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pp_reduce_sched.md
# pp_reduce_sched

Sequencing controller for the shared 24-bit 7:2 compressor (`compressor7to2`) in the multi-precision PE. It accepts a variable-length stream of 24-bit partial-product rows and batches them five per pass into the single compressor instance. The remaining two compressor inputs carry the running sum/carry accumulator. After the last row it performs the final carry-propagate add and presents the 24-bit reduced result through a valid/ready handshake.

## Interface

Parameters:
- `WIDTH`, 24: row width; fixed by the compressor instance, and no other value is supported.
- `CNT_W`, 8: width of the row and pass counters.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: `in_row` / `in_last` are valid.
- `in_ready`, out, 1: block can accept a row this cycle.
- `in_row`, in, WIDTH: partial-product row, already aligned.
- `in_last`, in, 1: this row is the final row of the operation.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_result`, out, WIDTH: sum of all rows of the operation, mod 2^24.
- `out_rows`, out, CNT_W: number of rows in the operation, saturating at 2^CNT_W−1.
- `out_passes`, out, CNT_W: number of compressor passes used, saturating.

## Operation

- Transfer rules:
  - An input transfer occurs when `in_valid` and `in_ready` are both high.
  - An output transfer occurs when `out_valid` and `out_ready` are both high.
- Internal state:
  - Five row slots and a slot count 0..5.
  - Accumulators `acc_s` and `acc_c`, each WIDTH bits.
  - A `last_seen` flag and the row/pass counters.
- Compressor input mapping:
  - P0..P4 = slots 0..4; unfilled slots are driven with 0.
  - P5 = `acc_s`.
  - P6 = `acc_c << 1`, truncated to WIDTH.
- Invariant: `acc_s + (acc_c << 1)` equals the sum of all compressed rows mod 2^24.
- State machine, states COLLECT, COMPRESS, ADD, DONE:
  - COLLECT (reset state):
    - `in_ready` = 1.
    - Each input transfer writes `in_row` into slot[count], increments count and increments the row counter.
    - Go to COMPRESS after the transfer that makes count 5, or after any transfer with `in_last` = 1. The latter also sets `last_seen`.
    - If `in_valid` = 0, hold.
  - COMPRESS (exactly one cycle):
    - `in_ready` = 0.
    - Load `acc_s` ← `sum` and `acc_c` ← `carry` from the compressor.
    - Clear the slots and count; increment the pass counter.
    - Go to ADD if `last_seen`, else back to COLLECT.
  - ADD (one cycle):
    - Register `out_result` ← (`acc_s` + (`acc_c` << 1)) mod 2^24.
    - Latch the row and pass counters into `out_rows` and `out_passes`.
    - Clear the accumulators, the counters and `last_seen`.
    - Go to DONE.
  - DONE:
    - `out_valid` = 1 and `in_ready` = 0.
    - Outputs are held stable until the output transfer, then go to COLLECT.
- An operation always contains at least one row, because `in_last` travels with a row.
- Rows presented while `in_ready` = 0 are not consumed; the upstream must hold them.
- Counters saturate rather than wrap.
- Passes per operation = ceil(rows/5).

## Timing

- Reset values:
  - `in_ready` = 0 during reset; 1 in the first cycle after reset (COLLECT).
  - `out_valid` = 0.
  - `out_result`, `out_rows`, `out_passes` = 0.
  - All slots, accumulators, counters and `last_seen` = 0.
- Reset is sampled every cycle. Asserting `rst_n` = 0 in any state aborts the operation and returns all of the above to reset values on the next edge, with no partial output.
- Throughput: 5 rows per 6 cycles when streaming (5 accept cycles + 1 COMPRESS cycle with `in_ready` low).
- Latency: if the `in_last` row is accepted at edge t, then COMPRESS occupies cycle t+1, ADD occupies t+2, and `out_valid` is high from t+3.
- Minimum cycles from entering DONE to accepting the next row: 1. The output transfer at edge u gives `in_ready` = 1 in cycle u+1.
- No combinational path from `out_ready` to `in_ready` or from `in_valid` to `in_ready`; `in_ready` is a function of state only.
- The compressor is combinational between the slot/accumulator registers and the accumulator registers; no other logic lies in that path.

## Test plan

- Single row: one row 0x000001 with `in_last` → `out_result` = 0x000001, `out_rows` = 1, `out_passes` = 1, `out_valid` asserted 3 cycles after the accept edge.
- Wrap-around: 7 rows of 0xFFFFFF, last on the 7th → `out_result` = 0xFFFFF9, `out_rows` = 7, `out_passes` = 2; `in_ready` low for exactly one cycle after the 5th row.
- Exact batch: 5 rows 0x100000, 0x200000, 0x300000, 0x400000, 0x500000 with last on the 5th → `out_result` = 0xF00000, `out_passes` = 1.
- Streaming with upstream gaps: 12 rows with values 1..12, `in_valid` dropped for 2 cycles after rows 3 and 8 → `out_result` = 0x00004E, `out_rows` = 12, `out_passes` = 3; no row lost or duplicated.
- Backpressure: after the 0x00004E result, hold `out_ready` = 0 for 10 cycles → `out_valid` and all outputs stable and `in_ready` = 0 throughout; release → next row accepted in the following cycle, and a follow-on single row 0x000007 gives 0x000007.
- Reset mid-operation: accept 3 rows, assert `rst_n` low for 1 cycle during COLLECT → all outputs at reset values; then a single row 0x000005 with last → `out_result` = 0x000005 with no residue from the aborted rows.
